// File: rtl/nvio_enq_pkg.sv
// Shared types and constants for the fetch-bundle enqueue scheduler.
package nvio_enq_pkg;

   localparam int QSLOTS = 3;
   localparam int FREEW  = 4;
   localparam int LSMW   = 5;

   typedef enum logic {
      IDLE = 1'b0,
      LSM  = 1'b1
   } enq_state_t;

   function automatic logic [1:0] first_valid(input logic [QSLOTS-1:0] v);
      first_valid = 2'd0;
      for (int k = QSLOTS - 1; k >= 0; k--) begin
         if (v[k]) first_valid = 2'(k);
      end
   endfunction

endpackage

// File: rtl/enq_scan.sv
// Combinational in-order scan of a fresh bundle against the free-entry budget;
// stops at the first LSM slot, which the caller sequences.
module enq_scan
   import nvio_enq_pkg::*;
(
   input  logic [QSLOTS-1:0] slotv,
   input  logic [QSLOTS-1:0] slot_lsm,
   input  logic [FREEW-1:0]  q_free,
   output logic [QSLOTS-1:0] enq_v,
   output logic [2:0]        queued_cnt,
   output logic              hit_lsm,
   output logic [1:0]        lsm_k
);

   logic [FREEW-1:0] budget;
   logic             stop;

   always_comb begin
      enq_v      = '0;
      queued_cnt = 3'd0;
      hit_lsm    = 1'b0;
      lsm_k      = 2'd0;
      budget     = q_free;
      stop       = 1'b0;
      for (int k = 0; k < QSLOTS; k++) begin
         if (slotv[k] && !stop) begin
            if (budget == '0) begin
               stop = 1'b1;
            end else if (slot_lsm[k]) begin
               // LSM slot: first micro-op issues here, completion decided by caller
               enq_v[k] = 1'b1;
               hit_lsm  = 1'b1;
               lsm_k    = 2'(k);
               stop     = 1'b1;
            end else begin
               enq_v[k]   = 1'b1;
               queued_cnt = queued_cnt + 3'd1;
               budget     = budget - FREEW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/enqueue_sched.sv
// Enqueue scheduler top: IDLE/LSM sequencer around enq_scan, with all outputs
// combinational so slot tracking can consume them in the same cycle.
module enqueue_sched
   import nvio_enq_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   branchmiss,
   input  logic [QSLOTS-1:0]      slotv,
   input  logic [QSLOTS-1:0]      slot_lsm,
   input  logic [QSLOTS*LSMW-1:0] lsm_cnt,
   input  logic [FREEW-1:0]       q_free,
   output logic [2:0]             queuedCnt,
   output logic [QSLOTS-1:0]      lsm,
   output logic                   nextb,
   output logic [QSLOTS-1:0]      enq_v,
   output logic [LSMW-1:0]        uop_idx,
   output logic                   busy
);

   enq_state_t       st_q, st_d;
   logic [1:0]       lsm_slot_q, lsm_slot_d;
   logic [LSMW-1:0]  lsm_rem_q, lsm_rem_d;
   logic [LSMW-1:0]  lsm_idx_q, lsm_idx_d;

   logic [QSLOTS-1:0] sc_enq_v;
   logic [2:0]        sc_cnt;
   logic              sc_hit;
   logic [1:0]        sc_k;

   logic [LSMW-1:0]   n_raw, n_eff;
   logic [QSLOTS-1:0] held_oh, new_oh, consumed;

   enq_scan u_scan (
      .slotv      (slotv),
      .slot_lsm   (slot_lsm),
      .q_free     (q_free),
      .enq_v      (sc_enq_v),
      .queued_cnt (sc_cnt),
      .hit_lsm    (sc_hit),
      .lsm_k      (sc_k)
   );

   assign held_oh = QSLOTS'(1) << lsm_slot_q;
   assign new_oh  = QSLOTS'(1) << sc_k;

   always_comb begin
      n_raw = '0;
      for (int k = 0; k < QSLOTS; k++) begin
         if (sc_k == 2'(k)) n_raw = lsm_cnt[k*LSMW +: LSMW];
      end
      n_eff = (n_raw == '0) ? LSMW'(1) : n_raw;
   end

   always_comb begin
      st_d       = st_q;
      lsm_slot_d = lsm_slot_q;
      lsm_rem_d  = lsm_rem_q;
      lsm_idx_d  = lsm_idx_q;
      queuedCnt  = 3'd0;
      lsm        = '0;
      enq_v      = '0;
      uop_idx    = '0;
      consumed   = '0;
      busy       = (st_q == LSM);

      if (st_q == IDLE) begin
         enq_v     = sc_enq_v;
         queuedCnt = sc_cnt;
         consumed  = sc_enq_v;
         if (sc_hit) begin
            if (n_eff == LSMW'(1)) begin
               queuedCnt = sc_cnt + 3'd1;
            end else begin
               lsm        = new_oh;
               consumed   = sc_enq_v & ~new_oh;
               st_d       = LSM;
               lsm_slot_d = sc_k;
               lsm_rem_d  = n_eff - LSMW'(1);
               lsm_idx_d  = LSMW'(1);
            end
         end
      end else begin
         if (q_free != '0 && (slotv & held_oh) != '0) begin
            enq_v     = held_oh;
            uop_idx   = lsm_idx_q;
            lsm_idx_d = lsm_idx_q + LSMW'(1);
            lsm_rem_d = lsm_rem_q - LSMW'(1);
            if (lsm_rem_q == LSMW'(1)) begin
               queuedCnt = 3'd1;
               consumed  = held_oh;
               st_d      = IDLE;
               lsm_rem_d = '0;
               lsm_idx_d = '0;
            end else begin
               lsm = held_oh;
            end
         end else begin
            lsm = held_oh;
         end
      end

      nextb = (consumed == slotv);

      // A flush kills everything in flight, including a completing LSM.
      if (branchmiss) begin
         st_d       = IDLE;
         lsm_slot_d = '0;
         lsm_rem_d  = '0;
         lsm_idx_d  = '0;
      end
      if (branchmiss || !rst) begin
         queuedCnt = 3'd0;
         lsm       = '0;
         enq_v     = '0;
         uop_idx   = '0;
         nextb     = 1'b0;
         busy      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q       <= IDLE;
         lsm_slot_q <= '0;
         lsm_rem_q  <= '0;
         lsm_idx_q  <= '0;
      end else begin
         st_q       <= st_d;
         lsm_slot_q <= lsm_slot_d;
         lsm_rem_q  <= lsm_rem_d;
         lsm_idx_q  <= lsm_idx_d;
      end
   end

endmodule
